// File: rtl/stopwatch_bcd.sv
// Centisecond BCD stopwatch (HH:MM:SS.cc) with debounced start/stop, lap and clear buttons.
// A lap freezes the display on a captured time while the live count keeps running underneath.

module stopwatch_bcd_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            press_q;
  logic            press_d;

  // The counter tracks how long the synchronised input has disagreed with the
  // accepted level; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module stopwatch_bcd #(
  parameter int TICK_DIV     = 1000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [31:0] hex,
  output logic        running,
  output logic        lap_active
);

  localparam int PS_W = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2,
    LAP     = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PS_W-1:0]   presc_q;
  logic [PS_W-1:0]   presc_d;
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;
  logic [31:0]       lap_q;
  logic [31:0]       lap_d;
  logic [31:0]       hex_q;
  logic [31:0]       hex_d;
  logic              ss_press;
  logic              lap_press;
  logic              clr_press;
  logic              counting;
  logic              tick;
  logic              clear_now;

  stopwatch_bcd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_start_stop),
    .press   (ss_press)
  );

  stopwatch_bcd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_lap),
    .press   (lap_press)
  );

  stopwatch_bcd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clear),
    .press   (clr_press)
  );

  // Seconds tens and minutes tens roll over at 5; every other digit at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign counting  = (state_q == RUN) || (state_q == LAP);
  assign tick      = counting && (presc_q == PS_W'(TICK_DIV - 1));
  assign clear_now = (state_q == STOPPED) && clr_press;

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      IDLE: begin
        if (ss_press) state_d = RUN;
      end
      RUN: begin
        if (ss_press) begin
          state_d = STOPPED;
        end else if (lap_press) begin
          state_d = LAP;
          lap_d   = cnt_q;
        end
      end
      LAP: begin
        if (ss_press) begin
          state_d = STOPPED;
        end else if (lap_press) begin
          state_d = RUN;
        end
      end
      STOPPED: begin
        if (clr_press) begin
          state_d = IDLE;
        end else if (ss_press) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler and count hold while stopped so a resume keeps the partial tick.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (counting) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
    end
    if (tick) begin
      cnt_d = bcd_inc(cnt_q);
    end
    if (clear_now) begin
      presc_d = '0;
      cnt_d   = '0;
    end
    hex_d = (state_q == LAP) ? lap_q : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      hex_q   <= hex_d;
    end
  end

  assign hex        = hex_q;
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign lap_active = (state_q == LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICK_DIV=4 and DEBOUNCE_CYC=3.
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [31:0] hex;
  logic        running;
  logic        lap_active;

  int passed = 0;
  int total  = 0;
  logic [31:0] force_val;

  typedef struct {
    logic [31:0] start;
    logic [31:0] exp;
  } inc_vec_t;

  inc_vec_t vecs [8];

  stopwatch_bcd #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .hex            (hex),
    .running        (running),
    .lap_active     (lap_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_true(input string name, input logic ok, input logic [31:0] act);
    total++;
    if (ok === 1'b1) passed++;
    else $display("FAIL %s: got %h, outside the allowed values", name, act);
  endtask

  task automatic do_reset();
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_run(input logic lvl, input string name);
    int n = 0;
    while (running !== lvl && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, running}, {31'b0, lvl});
  endtask

  // Loads the count while idle; the count holds there, so one clock edge lands it.
  task automatic force_cnt(input logic [31:0] v);
    force_val = v;
    force dut.cnt_d = force_val;
    @(negedge clk);
    release dut.cnt_d;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0001};
    vecs[1] = '{32'h0000_0009, 32'h0000_0010};
    vecs[2] = '{32'h0000_0099, 32'h0000_0100};
    vecs[3] = '{32'h0000_5999, 32'h0001_0000};
    vecs[4] = '{32'h0059_5999, 32'h0100_0000};
    vecs[5] = '{32'h0959_5999, 32'h1000_0000};
    vecs[6] = '{32'h9959_5999, 32'h0000_0000};
    vecs[7] = '{32'h1234_5678, 32'h1234_5679};

    #1 reset = 1'b1;
    #2;
    chk("reset_hex", hex, 32'h0);
    chk("reset_running", {31'b0, running}, 32'h0);
    chk("reset_lap_active", {31'b0, lap_active}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Start latency and free-running count.
    do_reset();
    btn_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    chk("start_latency_5", {31'b0, running}, 32'h0);
    @(negedge clk);
    chk("start_latency_6", {31'b0, running}, 32'h1);
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (36) @(negedge clk);
    chk_true("run_40_cycles", (hex == 32'h09) || (hex == 32'h10) || (hex == 32'h11), hex);

    // Two-cycle glitch is rejected.
    do_reset();
    btn_start_stop = 1'b1;
    repeat (2) @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_running", {31'b0, running}, 32'h0);
    chk("glitch_hex", hex, 32'h0);

    // One tick from each loaded count.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      force_cnt(vecs[i].start);
      chk($sformatf("load[%0d]", i), hex, vecs[i].start);
      btn_start_stop = 1'b1;
      wait_run(1'b1, $sformatf("inc_start[%0d]", i));
      btn_start_stop = 1'b0;
      repeat (6) @(negedge clk);
      chk($sformatf("inc[%0d]", i), hex, vecs[i].exp);
    end

    // Lap capture at 00:00:01.23, then return to live display.
    do_reset();
    force_cnt(32'h0000_0120);
    btn_start_stop = 1'b1;
    wait_run(1'b1, "lap_start");
    btn_start_stop = 1'b0;
    repeat (8) @(negedge clk);
    btn_lap = 1'b1;
    repeat (5) @(negedge clk);
    btn_lap = 1'b0;
    repeat (7) @(negedge clk);
    chk("lap_hex", hex, 32'h0000_0123);
    chk("lap_active", {31'b0, lap_active}, 32'h1);
    chk("lap_running", {31'b0, running}, 32'h1);
    btn_lap = 1'b1;
    repeat (5) @(negedge clk);
    btn_lap = 1'b0;
    chk("lap_hex_held", hex, 32'h0000_0123);
    repeat (3) @(negedge clk);
    chk("unlap_hex_live", hex, 32'h0000_0126);
    chk("unlap_lap_active", {31'b0, lap_active}, 32'h0);

    // Clear ignored in RUN; clear beats start_stop in STOPPED.
    do_reset();
    btn_start_stop = 1'b1;
    wait_run(1'b1, "clr_start");
    btn_start_stop = 1'b0;
    btn_clear = 1'b1;
    repeat (5) @(negedge clk);
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
    chk("clear_in_run", {31'b0, running}, 32'h1);
    btn_start_stop = 1'b1;
    wait_run(1'b0, "stop");
    btn_start_stop = 1'b0;
    repeat (8) @(negedge clk);
    chk_true("stopped_nonzero", hex != 32'h0, hex);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    repeat (5) @(negedge clk);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    repeat (10) @(negedge clk);
    chk("clear_hex", hex, 32'h0);
    chk("clear_running", {31'b0, running}, 32'h0);

    // Reset mid-run with start_stop held.
    do_reset();
    btn_start_stop = 1'b1;
    wait_run(1'b1, "rst_start");
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_hex", hex, 32'h0);
    chk("midrun_reset_running", {31'b0, running}, 32'h0);
    chk("midrun_reset_lap", {31'b0, lap_active}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_no_early_start", {31'b0, running}, 32'h0);
    @(negedge clk);
    chk("held_start_after_6", {31'b0, running}, 32'h1);
    btn_start_stop = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
